tiny_rv_fetch: RTL and testbench
================================

# tiny_rv_fetch

Instruction-fetch stage of the tiny_rv core, directly upstream of `tiny_rv_decode`. It owns the program counter and issues word requests to the instruction-memory port, with at most one request outstanding. It presents one registered `fetch_pc`/`fetch_inst` pair to decode per accepting cycle. It absorbs pipeline stalls with a one-entry skid buffer and redirects on pipeline flush, discarding any in-flight stale response.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `i_clk` in 1: clock, rising edge.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_pipe_stall` in 1: decode is holding; the current `fetch_*` pair is not consumed this edge.
- `i_pipe_flush` in 1: redirect. Same signal that clears decode.
- `i_redirect_pc` in 32: new PC. Sampled only when `i_pipe_flush`=1.
- `o_imem_req` in→out 1: request valid.
- `o_imem_addr` out 32: word address. Bits [1:0] are always 0.
- `i_imem_gnt` in 1: request accepted this cycle.
- `i_imem_rvalid` in 1: response data valid. Arrives at least one cycle after `gnt`, in order.
- `i_imem_rdata` in 32: instruction word.
- `fetch_pc` out 32: PC of the presented instruction.
- `fetch_inst` out 32: presented instruction. A value of `32'h0` with `fetch_pc` 0 is a bubble.

## Operation
- **Internal state:**
  - `pc`: next address to request.
  - `outstanding`: one request granted and awaiting `rvalid`.
  - `drop`: the outstanding response is stale.
  - `out_valid`: the output pair holds a real instruction.
  - Skid entry: `skid_valid`, `skid_pc`, `skid_inst`.
  - Request PC FIFO of depth 1: `req_pc`, the PC of the outstanding request.
- **Request condition:** `o_imem_req = i_reset_n & !i_pipe_flush & !skid_valid & (!outstanding | i_imem_rvalid) & !(i_imem_rvalid & i_pipe_stall & out_valid)`.
- **Request address:** `o_imem_addr = pc`.
- **On `req & gnt`:** `outstanding`←1, `req_pc`←`pc`, `pc`←`pc+4` (32-bit, wraps at 2^32).
- **Response without `drop`** (`rvalid & !drop`) produces entry {`req_pc`, `rdata`}.
- **Response with `drop`** (`rvalid & drop`) is discarded and clears `drop`.
- `outstanding` clears on `rvalid` unless a new grant occurs in the same cycle.
- **Output update on each edge, in priority order:**
  1. `i_pipe_flush`:
     - Output←bubble, `out_valid`←0, `skid_valid`←0.
     - `pc`←{`i_redirect_pc[31:2]`, 2'b00}.
     - `drop`←`outstanding & !rvalid`.
  2. `i_pipe_stall & out_valid`: output holds. A fresh response goes to the skid.
  3. Otherwise the output is consumed (or empty), and the next output is chosen in order: skid (then `skid_valid`←0), else a fresh response, else bubble. `out_valid` reflects the choice.
- **Stall with a bubble at the output:** a fresh response loads directly into the output.
- **Skid occupancy:** the skid can never be written while full, because the request gating guarantees it.

## Timing
- **Reset values:**
  - `fetch_pc`=0, `fetch_inst`=0.
  - `pc`=`RESET_PC`.
  - `outstanding`, `drop`, `out_valid`, `skid_valid` all 0.
  - `o_imem_req`=0 while `i_reset_n`=0.
- **First request** is issued in the first cycle after reset deassertion.
- **Latency:** with a 1-cycle memory (`gnt` in cycle N, `rvalid` in cycle N+1), the instruction appears on `fetch_*` after edge N+1.
- **Throughput:** with a 1-cycle memory and no stalls, one instruction per cycle (back-to-back grant on the `rvalid` cycle).
- **Flush cycle:** no request is issued. The redirect request is issued the next cycle, or later if the stale response is still pending: `outstanding` blocks issue until the dropped `rvalid` returns.
- **Flush and `rvalid` in the same cycle:** the response is discarded, `drop` is not set, and `outstanding` clears.
- **Flush and stall asserted together:** flush wins.
- **Asynchronous reset mid-request:** all state clears immediately. A later `rvalid` for the pre-reset request is outside the protocol; the memory is reset with the core.

## Structure
- **Shared package `tiny_rv_pkg`:** `RV_BUBBLE_INST` (`32'h0`) and `RV_RESET_PC_DEFAULT`. The decode bubble encoding comes from the same constant.
- **One sub-module, `tiny_rv_fetch_skid`:**
  - One-entry pc/inst buffer with `wr`, `rd`, `clr`, `valid`.
  - Asynchronous active-low reset.
- **Top level:** request FSM and PC logic.

## Test plan
- Reset, 1-cycle memory returning `rdata`=`addr^32'hA5A5_0000`, no stall → `fetch_pc` sequence 0, 4, 8, 12 on consecutive cycles, each with the matching inst, and `o_imem_req` held high.
- `i_pipe_stall` for 3 cycles while `out_valid`, with a response arriving → output holds PC 8. The skid takes PC 12 and `o_imem_req` drops. On release, PC 12 follows PC 8 with no gap and no duplicate.
- Flush with `i_redirect_pc`=`32'h0000_0103` while a request is outstanding → stale `rvalid` discarded, next request address `32'h0000_0100`, output is a bubble until PC `0x100` arrives.
- Flush coincident with `rvalid`, and flush coincident with stall → response dropped, bubble output, redirect request on the following cycle.
- `gnt` delayed 4 cycles and `rvalid` delayed 3 cycles → `o_imem_req`/`o_imem_addr` stay stable until `gnt`, bubbles are emitted meanwhile, and the PC order is preserved.
- `RESET_PC`=`32'hFFFF_FFF8`, run 4 fetches → addresses `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`, `0000_0004`. Asserting `i_reset_n`=0 mid-run clears all outputs asynchronously.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// ---------------------------------------------------------------------------
// tiny_rv_pkg
// Shared constants and types for the tiny_rv core.
//   RV_BUBBLE_INST / RV_BUBBLE_PC : encoding of an empty slot between stages
//                                   (decode uses the same constant).
//   RV_RESET_PC_DEFAULT           : default first fetch address.
//   fetch_req_state_e             : imem request tracking state of fetch.
//   rv_word_align()               : clears the byte-offset bits of an address.
// ---------------------------------------------------------------------------
package tiny_rv_pkg;

    localparam logic [31:0] RV_BUBBLE_INST      = 32'h0000_0000;
    localparam logic [31:0] RV_BUBBLE_PC        = 32'h0000_0000;
    localparam logic [31:0] RV_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RV_INST_BYTES       = 32'd4;

    // IDLE : nothing outstanding
    // BUSY : one request granted, its response is wanted
    // STALE: one request granted, its response must be thrown away
    typedef enum logic [1:0] {
        REQ_IDLE  = 2'b00,
        REQ_BUSY  = 2'b01,
        REQ_STALE = 2'b10
    } fetch_req_state_e;

    function automatic logic [31:0] rv_word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/tiny_rv_fetch_skid.sv
// ---------------------------------------------------------------------------
// tiny_rv_fetch_skid
// One-entry pc/inst holding buffer that catches a response arriving while
// decode is stalled on a valid instruction.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   wr               : load wr_pc/wr_inst (only issued while empty)
//   rd               : entry consumed this edge
//   clr              : drop the entry (flush), wins over wr/rd
//   valid, pc, inst  : current entry
// ---------------------------------------------------------------------------
module tiny_rv_fetch_skid
    import tiny_rv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    input  logic [DATA_W-1:0] wr_pc,
    input  logic [DATA_W-1:0] wr_inst,
    output logic              valid,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] inst
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
        end else if (rd) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (wr && !clr) begin
            pc   <= wr_pc;
            inst <= wr_inst;
        end
    end

endmodule

// File: rtl/tiny_rv_fetch.sv
// ---------------------------------------------------------------------------
// tiny_rv_fetch
// Instruction-fetch stage: owns the PC, issues one word request at a time to
// instruction memory and presents one registered pc/inst pair to decode.
// Stalls are absorbed by a one-entry skid; a flush redirects the PC and
// discards any response still in flight.
//   RESET_PC         : first address fetched after reset
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_pipe_stall     : decode does not consume the current pair
//   i_pipe_flush     : redirect to i_redirect_pc, output becomes a bubble
//   o_imem_req/addr  : request valid / word address
//   i_imem_gnt       : request accepted
//   i_imem_rvalid    : response valid (in order, >=1 cycle after gnt)
//   i_imem_rdata     : response instruction word
//   fetch_pc/inst    : presented pair, {0,0} is a bubble
// ---------------------------------------------------------------------------
module tiny_rv_fetch
    import tiny_rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst
);

    fetch_req_state_e req_state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             out_valid;

    logic             outstanding;
    logic             drop;
    logic             fresh;
    logic             hold;
    logic             fire;
    logic             skid_wr;
    logic             skid_rd;
    logic             skid_valid;
    logic [31:0]      skid_pc;
    logic [31:0]      skid_inst;

    always_comb begin
        outstanding = (req_state != REQ_IDLE);
        drop        = (req_state == REQ_STALE);
        fresh       = i_imem_rvalid & ~drop;
        hold        = i_pipe_stall & out_valid;
        // Never request while a response could land with nowhere to go:
        // skid full, or the response of this cycle is about to fill it.
        o_imem_req  = i_reset_n & ~i_pipe_flush & ~skid_valid
                    & (~outstanding | i_imem_rvalid)
                    & ~(i_imem_rvalid & hold);
        o_imem_addr = pc;
        fire        = o_imem_req & i_imem_gnt;
        skid_wr     = ~i_pipe_flush & hold & fresh;
        skid_rd     = ~i_pipe_flush & ~hold & skid_valid;
    end

    tiny_rv_fetch_skid #(
        .DATA_W (32)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .wr        (skid_wr),
        .rd        (skid_rd),
        .clr       (i_pipe_flush),
        .wr_pc     (req_pc),
        .wr_inst   (i_imem_rdata),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_state  <= REQ_IDLE;
            pc         <= RESET_PC;
            req_pc     <= RV_BUBBLE_PC;
            out_valid  <= 1'b0;
            fetch_pc   <= RV_BUBBLE_PC;
            fetch_inst <= RV_BUBBLE_INST;
        end else begin
            // ---- request side: PC and outstanding/drop tracking ----
            if (i_pipe_flush) begin
                pc <= rv_word_align(i_redirect_pc);
                // A response arriving in the flush cycle is simply ignored;
                // only a still-pending one has to be marked stale.
                req_state <= (outstanding && !i_imem_rvalid) ? REQ_STALE : REQ_IDLE;
            end else if (fire) begin
                pc        <= pc + RV_INST_BYTES;
                req_pc    <= pc;
                req_state <= REQ_BUSY;
            end else if (i_imem_rvalid) begin
                req_state <= REQ_IDLE;
            end

            // ---- output side: pair presented to decode ----
            if (i_pipe_flush) begin
                out_valid  <= 1'b0;
                fetch_pc   <= RV_BUBBLE_PC;
                fetch_inst <= RV_BUBBLE_INST;
            end else if (!hold) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    fetch_pc   <= skid_pc;
                    fetch_inst <= skid_inst;
                end else if (fresh) begin
                    out_valid  <= 1'b1;
                    fetch_pc   <= req_pc;
                    fetch_inst <= i_imem_rdata;
                end else begin
                    out_valid  <= 1'b0;
                    fetch_pc   <= RV_BUBBLE_PC;
                    fetch_inst <= RV_BUBBLE_INST;
                end
            end
        end
    end

endmodule

// File: tb/tb_tiny_rv_fetch.sv
// ---------------------------------------------------------------------------
// tb_tiny_rv_fetch
// Drives tiny_rv_fetch with a configurable-latency instruction memory and
// random stall/flush traffic. Expected program order comes from a reference
// model: sequential PCs from the last (re)start point, each instruction word
// being pc ^ KEY. A second instance with a wrapping RESET_PC checks address
// wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_tiny_rv_fetch;
    import tiny_rv_pkg::*;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] RESET2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, gnt, rvalid, req;
    logic [31:0] redirect, rdata, addr, fpc, finst;

    logic        rst2_n, gnt2, rvalid2, req2;
    logic [31:0] rdata2, addr2, fpc2, finst2;
    logic        stall2, flush2;
    logic [31:0] redirect2;

    always #5 clk = ~clk;

    tiny_rv_fetch dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_pipe_stall(stall), .i_pipe_flush(flush),
        .i_redirect_pc(redirect), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .fetch_pc(fpc), .fetch_inst(finst)
    );

    tiny_rv_fetch #(.RESET_PC(RESET2)) dut2 (
        .i_clk(clk), .i_reset_n(rst2_n), .i_pipe_stall(stall2), .i_pipe_flush(flush2),
        .i_redirect_pc(redirect2), .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_gnt(gnt2), .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2),
        .fetch_pc(fpc2), .fetch_inst(finst2)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input bit ok, input string nm,
                                input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // reference model / scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_cons;
    int          idle, max_idle;
    bit          mon_en;

    // memory model state
    bit          pend_valid, granted, wait_prev;
    logic [31:0] pend_addr, g_addr, wait_addr;
    int          pend_cnt, gwait;
    int          lat_lo, lat_hi, g_lo, g_hi;

    // Monitor: a non-bubble pair seen with no stall/flush is consumed this edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (finst == RV_BUBBLE_INST) begin
                chk(fpc == RV_BUBBLE_PC, "bubble_pc", fpc, RV_BUBBLE_PC);
            end else if (!stall && !flush) begin
                n_cons++;
                idle = 0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_inst", fpc, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk(fpc == e, "fetch_pc", fpc, e);
                    chk(finst == (e ^ KEY), "fetch_inst", finst, e ^ KEY);
                end
            end
        end
    end

    // One clock of stimulus. fl_mode: 0 none, 1 flush, 2 flush only if rvalid.
    task automatic step(input logic st, input int fl_mode, input logic [31:0] rpc,
                        output bit flushed);
        @(posedge clk);
        #1;
        if (rvalid) pend_valid = 1'b0;
        if (granted) begin
            pend_valid = 1'b1;
            pend_addr  = g_addr;
            pend_cnt   = $urandom_range(lat_hi, lat_lo);
        end
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = pend_addr ^ KEY;
            end else begin
                pend_cnt--;
            end
        end
        flushed  = (fl_mode == 1) || (fl_mode == 2 && rvalid);
        stall    = st;
        flush    = flushed;
        redirect = rpc;
        if (flushed) begin
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end
        #1;
        if (wait_prev && req && !flushed)
            chk(addr == wait_addr, "addr_stable", addr, wait_addr);
        granted = 1'b0;
        gnt     = 1'b0;
        if (req) begin
            if (gwait == 0) begin
                gnt     = 1'b1;
                granted = 1'b1;
                g_addr  = addr;
                chk(addr == model_pc, "req_addr", addr, model_pc);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                gwait = $urandom_range(g_hi, g_lo);
            end else begin
                gwait--;
            end
        end
        wait_prev = req && !gnt;
        wait_addr = addr;
        idle++;
        if (idle > max_idle) max_idle = idle;
    endtask

    initial begin
        bit f;
        int base;
        rst_n = 0; stall = 0; flush = 0; gnt = 0; rvalid = 0; redirect = 0; rdata = 0;
        rst2_n = 0; gnt2 = 0; rvalid2 = 0; rdata2 = 0; stall2 = 0; flush2 = 0; redirect2 = 0;
        mon_en = 0; n_cons = 0; idle = 0; max_idle = 0;
        pend_valid = 0; granted = 0; wait_prev = 0; pend_cnt = 0; gwait = 0;
        pend_addr = 0; g_addr = 0; wait_addr = 0;
        lat_lo = 0; lat_hi = 0; g_lo = 0; g_hi = 0;
        model_pc = RV_RESET_PC_DEFAULT;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(req == 1'b0, "reset_req", {31'b0, req}, 32'h0);
        chk(fpc == 32'h0, "reset_fetch_pc", fpc, 32'h0);
        chk(finst == 32'h0, "reset_fetch_inst", finst, 32'h0);
        chk(req2 == 1'b0, "reset_req2", {31'b0, req2}, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1-cycle memory, no stall: one instruction per cycle after 2 cycles
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 32'h0, f);
            chk(req == 1'b1, "req_held", {31'b0, req}, 32'h1);
        end
        @(negedge clk); #1;
        chk(n_cons == 10, "throughput", n_cons, 32'd10);

        // 3-cycle stall with a response landing: skid fills, requests stop
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, 32'h0, f);
            chk(req == 1'b0, "stall_req_low", {31'b0, req}, 32'h0);
        end
        base = n_cons;
        step(1'b0, 0, 32'h0, f);
        step(1'b0, 0, 32'h0, f);
        @(negedge clk); #1;
        chk(n_cons - base == 2, "skid_no_gap", n_cons - base, 32'd2);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 32'h0, f);

        // flush while a slow response is outstanding
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(pend_valid && pend_cnt >= 1); i++) step(1'b0, 0, 32'h0, f);
        step(1'b0, 1, 32'h0000_0103, f);
        step(1'b0, 0, 32'h0, f);
        chk(finst == RV_BUBBLE_INST, "flush_bubble", finst, RV_BUBBLE_INST);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 32'h0, f);

        // flush coincident with rvalid, without and with stall
        lat_lo = 0; lat_hi = 0;
        for (int k = 0; k < 2; k++) begin
            f = 0;
            for (int i = 0; i < 20 && !f; i++)
                step(k == 1, 2, (k == 1) ? 32'h0000_0300 : 32'h0000_0200, f);
            chk(f, "flush_on_rvalid", {31'b0, f}, 32'h1);
            step(1'b0, 0, 32'h0, f);
            chk(req == 1'b1, "redirect_next_cycle", {31'b0, req}, 32'h1);
            chk(finst == RV_BUBBLE_INST, "flush_rv_bubble", finst, RV_BUBBLE_INST);
            for (int i = 0; i < 8; i++) step(1'b0, 0, 32'h0, f);
        end

        // slow memory: grant after 4 waits, response 3 cycles late
        g_lo = 4; g_hi = 4; lat_lo = 3; lat_hi = 3;
        gwait = 4;
        for (int i = 0; i < 40; i++) step(1'b0, 0, 32'h0, f);

        // randomized traffic
        g_lo = 0; g_hi = 3; lat_lo = 0; lat_hi = 3;
        idle = 0; max_idle = 0;
        for (int i = 0; i < 3000; i++) begin
            int fm;
            fm = ($urandom_range(99, 0) < 3) ? int'($urandom_range(2, 1)) : 0;
            step($urandom_range(3, 0) == 0, fm, $urandom & 32'h000F_FFFF, f);
        end
        chk(max_idle <= 400, "progress", max_idle, 32'd400);
        mon_en = 1'b0;

        // wrapping reset PC on the second instance, then async reset
        begin
            bit          g2;
            logic [31:0] e;
            g2 = 0;
            @(negedge clk);
            rst2_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                rvalid2 = g2;
                rdata2  = addr2 ^ KEY;
                if (g2) rdata2 = (RESET2 + 32'(4 * (k - 1))) ^ KEY;
                #1;
                gnt2 = req2;
                g2   = req2;
                if (k < 4) begin
                    e = RESET2 + 32'(4 * k);
                    chk(addr2 == e, "wrap_addr", addr2, e);
                end
                if (k >= 2) begin
                    e = RESET2 + 32'(4 * (k - 2));
                    chk(fpc2 == e, "wrap_fetch_pc", fpc2, e);
                    chk(finst2 == (e ^ KEY), "wrap_fetch_inst", finst2, e ^ KEY);
                end
            end
            #1;
            rst2_n = 1'b0;
            #1;
            chk(fpc2 == 32'h0, "async_rst_pc", fpc2, 32'h0);
            chk(finst2 == 32'h0, "async_rst_inst", finst2, 32'h0);
            chk(req2 == 1'b0, "async_rst_req", {31'b0, req2}, 32'h0);
            gnt2 = 0; rvalid2 = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
